dead_time_gen: RTL and testbench

DEAD_TIME_GEN -- requirements
Module: dead_time_gen

---
 rtl/drsstc_pkg.sv | 22 ++
 rtl/sync2.sv | 27 ++
 rtl/dead_time_gen.sv | 127 ++++++++++++
 tb/tb_dead_time_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/drsstc_pkg.sv
// Shared types and defaults for the DRSSTC bridge driver blocks.
package drsstc_pkg;

    // Bridge controller states.
    typedef enum logic [2:0] {
        StOff,
        StDead,
        StPos,
        StNeg,
        StFault
    } state_e;

    // 100 ns dead time and 200 ns minimum on-time at 100 MHz.
    localparam int unsigned DefDeadCyc  = 10;
    localparam int unsigned DefMinOnCyc = 20;

    // Counter width wide enough for the larger interval, plus one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Shift the input through two flops; reset clears both stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dead_time_gen.sv
// Full-bridge gate sequencer with dead time, minimum on-time and latched over-current trip.
module dead_time_gen
    import drsstc_pkg::*;
#(
    parameter int unsigned DEAD_CYC   = DefDeadCyc,
    parameter int unsigned MIN_ON_CYC = DefMinOnCyc
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic phase,
    input  logic ocd,
    input  logic clr_fault,
    output logic a_hi,
    output logic a_lo,
    output logic b_hi,
    output logic b_lo,
    output logic fault
);

    localparam int unsigned CntW = cnt_width(DEAD_CYC, MIN_ON_CYC);
    localparam logic [CntW-1:0] DeadLoad  = CntW'(DEAD_CYC - 1);
    localparam logic [CntW-1:0] MinOnLoad = CntW'(MIN_ON_CYC - 1);

    // Gate vector order: {a_hi, a_lo, b_hi, b_lo}.
    localparam logic [3:0] GatesPos = 4'b1001;
    localparam logic [3:0] GatesNeg = 4'b0110;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      gates_q, gates_d;
    logic            fault_q;
    logic            ocd_sync;
    logic            cnt_done;

    sync2 #(
        .WIDTH(1)
    ) u_ocd_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ocd),
        .q    (ocd_sync)
    );

    assign cnt_done = (cnt_q == '0);

    // Next-state and interval counter; over-current trumps every other condition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_done ? cnt_q : cnt_q - 1'b1;
        if (ocd_sync) begin
            state_d = StFault;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    if (en) begin
                        state_d = StDead;
                        cnt_d   = DeadLoad;
                    end
                end
                StDead: begin
                    if (cnt_done) begin
                        if (!en) begin
                            state_d = StOff;
                        end else begin
                            state_d = phase ? StPos : StNeg;
                            cnt_d   = MinOnLoad;
                        end
                    end
                end
                StPos: begin
                    // A pending exit request simply waits here until min-on expires.
                    if (cnt_done && (!en || !phase)) begin
                        state_d = StDead;
                        cnt_d   = DeadLoad;
                    end
                end
                StNeg: begin
                    if (cnt_done && (!en || phase)) begin
                        state_d = StDead;
                        cnt_d   = DeadLoad;
                    end
                end
                StFault: begin
                    cnt_d = '0;
                    if (clr_fault) begin
                        state_d = StOff;
                    end
                end
                default: begin
                    state_d = StOff;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Decode gates from the next state so the registered gates track the state register.
    always_comb begin
        gates_d = 4'b0000;
        if (state_d == StPos) begin
            gates_d = GatesPos;
        end else if (state_d == StNeg) begin
            gates_d = GatesNeg;
        end
    end

    // State, counter and registered outputs; reset drops all gates on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StOff;
            cnt_q   <= '0;
            gates_q <= 4'b0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gates_q <= gates_d;
            fault_q <= (state_d == StFault);
        end
    end

    assign {a_hi, a_lo, b_hi, b_lo} = gates_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_dead_time_gen.sv
// Self-checking bench for dead_time_gen: directed segment table plus randomized model comparison.
module tb_dead_time_gen;

    localparam int DeadCyc  = 10;
    localparam int MinOnCyc = 20;
    localparam int RandCyc  = 20000;

    logic clk = 1'b0;
    logic rst_n, en, phase, ocd, clr_fault;
    logic a_hi, a_lo, b_hi, b_lo, fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dead_time_gen #(
        .DEAD_CYC  (DeadCyc),
        .MIN_ON_CYC(MinOnCyc)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .phase    (phase),
        .ocd      (ocd),
        .clr_fault(clr_fault),
        .a_hi     (a_hi),
        .a_lo     (a_lo),
        .b_hi     (b_hi),
        .b_lo     (b_lo),
        .fault    (fault)
    );

    // One row holds inputs for n cycles and the {a_hi,a_lo,b_hi,b_lo} / fault expected throughout.
    typedef struct {
        logic       en;
        logic       phase;
        logic       ocd;
        logic       clr;
        int         n;
        logic [3:0] gates;
        logic       flt;
        string      name;
    } seg_t;

    seg_t tbl[$];

    function automatic seg_t mk(input logic e, input logic p, input logic o, input logic c,
                                input int n, input logic [3:0] g, input logic f,
                                input string name);
        seg_t s;
        s.en = e; s.phase = p; s.ocd = o; s.clr = c;
        s.n = n; s.gates = g; s.flt = f; s.name = name;
        return s;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({a_hi, a_lo, b_hi, b_lo, fault});
    endfunction

    task automatic run_seg(input seg_t s);
        en = s.en; phase = s.phase; ocd = s.ocd; clr_fault = s.clr;
        for (int k = 0; k < s.n; k++) begin
            @(posedge clk);
            #1;
            check(s.name, outs(), int'({s.gates, s.flt}));
        end
    endtask

    task automatic do_reset(input logic hold_en, input logic hold_phase);
        rst_n = 1'b0; en = hold_en; phase = hold_phase; ocd = 1'b0; clr_fault = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state", outs(), 0);
        rst_n = 1'b1;
    endtask

    // Behavioural reference: state named by int, time in state counted upward.
    // 0 off, 1 dead, 2 pos, 3 neg, 4 fault.
    int   m_st, m_age;
    logic m_s1, m_s2;

    task automatic model_reset();
        m_st = 0; m_age = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic p, input logic o, input logic c);
        int nxt;
        nxt = m_st;
        if (m_s2) begin
            nxt = 4;
        end else begin
            case (m_st)
                0: if (e) nxt = 1;
                1: if (m_age >= DeadCyc - 1) nxt = !e ? 0 : (p ? 2 : 3);
                2: if (m_age >= MinOnCyc - 1 && (!e || !p)) nxt = 1;
                3: if (m_age >= MinOnCyc - 1 && (!e || p)) nxt = 1;
                4: if (c) nxt = 0;
                default: nxt = 0;
            endcase
        end
        m_s2  = m_s1;
        m_s1  = o;
        m_age = (nxt == m_st) ? m_age + 1 : 0;
        m_st  = nxt;
    endtask

    function automatic int model_out();
        case (m_st)
            2:       return 'b10010;
            3:       return 'b01100;
            4:       return 'b00001;
            default: return 0;
        endcase
    endfunction

    initial begin
        int last_drive;
        int off_run;
        int ocd_left;

        rst_n = 1'b0; en = 1'b0; phase = 1'b0; ocd = 1'b0; clr_fault = 1'b0;

        // Startup, min-on hold, burst end, fault trip and clear.
        tbl.push_back(mk(1, 1, 0, 0, 10, 4'b0000, 0, "startup_dead"));
        tbl.push_back(mk(1, 1, 0, 0,  5, 4'b1001, 0, "startup_pos"));
        tbl.push_back(mk(1, 0, 0, 1, 15, 4'b1001, 0, "min_on_hold"));
        tbl.push_back(mk(1, 0, 0, 0, 10, 4'b0000, 0, "pos_neg_dead"));
        tbl.push_back(mk(1, 0, 0, 0, 25, 4'b0110, 0, "neg_drive"));
        tbl.push_back(mk(0, 0, 0, 0, 10, 4'b0000, 0, "burst_end_dead"));
        tbl.push_back(mk(0, 0, 0, 0,  3, 4'b0000, 0, "burst_end_off"));
        tbl.push_back(mk(1, 1, 0, 0, 10, 4'b0000, 0, "reburst_dead"));
        tbl.push_back(mk(1, 1, 0, 0,  3, 4'b1001, 0, "reburst_pos"));
        tbl.push_back(mk(1, 1, 1, 0,  2, 4'b1001, 0, "ocd_sync_delay"));
        tbl.push_back(mk(1, 1, 1, 0,  3, 4'b0000, 1, "ocd_trip"));
        tbl.push_back(mk(1, 1, 1, 1,  3, 4'b0000, 1, "clr_ignored_ocd"));
        tbl.push_back(mk(1, 1, 0, 0,  3, 4'b0000, 1, "fault_latched"));
        tbl.push_back(mk(1, 1, 0, 1,  1, 4'b0000, 0, "fault_cleared"));
        tbl.push_back(mk(0, 1, 0, 0,  2, 4'b0000, 0, "off_after_clear"));

        do_reset(1'b0, 1'b0);
        foreach (tbl[i]) run_seg(tbl[i]);

        // Reset while driving NEG drops gates on the same edge, then re-enters via DEAD.
        do_reset(1'b0, 1'b0);
        run_seg(mk(1, 0, 0, 0, 10, 4'b0000, 0, "pre_reset_dead"));
        run_seg(mk(1, 0, 0, 0,  4, 4'b0110, 0, "pre_reset_neg"));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_drive", outs(), 0);
        rst_n = 1'b1;
        run_seg(mk(1, 0, 0, 0, 10, 4'b0000, 0, "reentry_dead"));
        run_seg(mk(1, 0, 0, 0,  2, 4'b0110, 0, "reentry_neg"));

        // Randomized run against the reference model with overlap and dead-gap invariants.
        do_reset(1'b0, 1'b0);
        model_reset();
        last_drive = 0;
        off_run    = DeadCyc;
        ocd_left   = 0;
        for (int cyc = 0; cyc < RandCyc; cyc++) begin
            @(posedge clk);
            model_step(en, phase, ocd, clr_fault);
            #1;
            check("rand_model", outs(), model_out());
            check("leg_overlap", int'({a_hi & a_lo, b_hi & b_lo}), 0);
            if ({a_hi, a_lo, b_hi, b_lo} == 4'b0000) begin
                off_run++;
            end else begin
                int drive;
                drive = a_hi ? 1 : 2;
                if (last_drive != 0 && drive != last_drive) begin
                    check("dead_gap", int'(off_run >= DeadCyc), 1);
                end
                last_drive = drive;
                off_run    = 0;
            end
            if ($urandom_range(199) == 0) en = ~en;
            if ($urandom_range(7) == 0) phase = ~phase;
            clr_fault = ($urandom_range(19) == 0);
            if (ocd_left > 0) begin
                ocd_left--;
            end else if ($urandom_range(2999) == 0) begin
                ocd_left = int'($urandom_range(4, 1));
            end
            ocd = (ocd_left > 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
